soc_sram2ahb3: RTL and testbench
================================

// Module: soc_sram2ahb3
// PURPOSE
//   AHB3-Lite single-transfer bus master driven by an SRAM-style request port (req/gnt, rsp_valid).
//   It is the initiator counterpart of the SRAM-backed AHB3 slave, used by DMA engines and test
//   masters to reach on-chip memories. Address phase of transfer N+1 overlaps data phase of N;
//   at most one data phase outstanding.
// PARAMETERS
//   PLEN      32       byte-address width (haddr_o, addr_i)
//   XLEN      32       data width; legal 32,16,8
//   SW        derived  byte-select width: 4/2/1 for XLEN 32/16/8 (localparam)
//   BYTE_AW   derived  SW>>1, byte-in-word address bits (localparam)
//   HPROT     4'b0011  constant driven on ahb3_hprot_o (data, privileged)
// PORTS
//   ahb3_clk_i        in   1     clock, all logic on rising edge
//   ahb3_rst_i        in   1     reset, synchronous, active-high
//   req_i             in   1     request valid; addr/we/wdata/sel stable while req_i && !gnt_o
//   we_i              in   1     1=write, 0=read
//   addr_i            in   PLEN  byte address; low BYTE_AW bits ignored, offset derived from sel_i
//   wdata_i           in   XLEN  write data, lane-aligned
//   sel_i             in   SW    byte enables
//   gnt_o             out  1     request accepted this cycle (address phase completed)
//   rsp_valid_o       out  1     data phase completed this cycle
//   rsp_err_o         out  1     qualifies rsp_valid_o: bus ERROR or illegal sel_i
//   rdata_o           out  XLEN  read data, valid with rsp_valid_o && !we of that transfer
//   ahb3_hsel_o       out  1     = (ahb3_htrans_o == NONSEQ)
//   ahb3_haddr_o      out  PLEN  {addr_i[PLEN-1:BYTE_AW], offset from sel_i}
//   ahb3_hwdata_o     out  XLEN  registered write data for current data phase
//   ahb3_hwrite_o     out  1     = we_i during address phase
//   ahb3_hsize_o      out  3     BYTE/HWORD/WORD decoded from sel_i
//   ahb3_hburst_o     out  3     constant SINGLE (3'b000)
//   ahb3_hprot_o      out  4     constant HPROT
//   ahb3_htrans_o     out  2     IDLE or NONSEQ only
//   ahb3_hmastlock_o  out  1     constant 0
//   ahb3_hrdata_i     in   XLEN  slave read data
//   ahb3_hready_i     in   1     slave ready
//   ahb3_hresp_i      in   1     slave response, 1=ERROR
// BEHAVIOUR
//   - Address phase is combinational from req_i: htrans_o=NONSEQ when req_i && sel legal && !err1,
//     else IDLE. gnt_o = req_i && ahb3_hready_i && !err1.
//   - sel decode (XLEN=32): 0001/0010/0100/1000 -> BYTE, off 0/1/2/3; 0011/1100 -> HWORD, off 0/2;
//     1111 -> WORD, off 0. XLEN=16: 01/10 byte, 11 half. XLEN=8: 1 byte. Any other pattern
//     (incl. 0) is illegal: htrans IDLE, still granted, LOCAL_ERR data slot.
//   - Data-phase state DSTATE: D_NONE, D_BUS, D_LOCAL_ERR. On gnt_o: D_BUS (legal) or D_LOCAL_ERR;
//     hwdata/we latched. Without gnt and data phase done: D_NONE. Otherwise hold.
//   - D_BUS: rsp_valid_o = hready_i; rsp_err_o = hresp_i; rdata_o = hrdata_i (pass-through).
//   - D_LOCAL_ERR: rsp_valid_o=1, rsp_err_o=1 for exactly one cycle; no bus activity.
//   - ERROR protocol: hresp_i && !hready_i in D_BUS sets err1 (combinational) -> htrans forced IDLE,
//     gnt_o=0 that cycle; the pending request is not lost and re-issues next cycle.
//     Completion cycle (hresp && hready) gives rsp_valid_o=1, rsp_err_o=1.
//   - Wait states: hready_i=0 holds DSTATE, hwdata_o and the address-phase inputs (req_i side must
//     hold per handshake).
//   - Back-to-back: gnt_o and rsp_valid_o may assert in the same cycle (one per clock at 0 wait).
//   - Reset: DSTATE=D_NONE, hwdata_o=0, latched we=0; therefore gnt_o, rsp_valid_o, rsp_err_o = 0
//     and htrans_o=IDLE whenever req_i=0. Reset mid-transfer drops the data phase without response.
// STRUCTURE
//   - soc_ahb3_pkg: HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_BYTE/HWORD/WORD, dstate_t enum.
//   - Sub-module soc_ahb3_sel_decode (combinational): sel_i -> {legal, hsize, byte offset},
//     parameterised by XLEN.
// TESTING
//   1 Reset: hold ahb3_rst_i 2 clks -> htrans_o=IDLE, gnt_o=rsp_valid_o=rsp_err_o=0, hwdata_o=0.
//   2 Write addr=0x100, sel=1111, wdata=0xDEADBEEF, hready=1 -> NONSEQ, haddr=0x100, hsize=WORD,
//     gnt same cycle; next cycle hwdata=0xDEADBEEF, rsp_valid=1, rsp_err=0.
//   3 Read sel=0100 addr=0x204, slave 2 wait states, hrdata=0x00AB0000 -> haddr=0x206, hsize=BYTE;
//     rsp_valid after 3rd data cycle, rdata=0x00AB0000.
//   4 Back-to-back 4 writes 0x0,0x4,0x8,0xC at zero wait -> gnt every cycle, 4 rsp_valid
//     consecutive, hwdata matches order.
//   5 ERROR on first of two pipelined reads -> cycle1 htrans=IDLE, gnt=0; cycle2 rsp_err=1;
//     second read re-issued NONSEQ and completes with rsp_err=0.
//   6 Illegal sel=0101 -> gnt=1, htrans=IDLE, next cycle rsp_valid=1, rsp_err=1, no hsel.

Source files
------------

// File: rtl/soc_ahb3_pkg.sv
// AHB3-Lite encodings and data-phase state type
// shared by the SRAM-to-AHB3 master and its helpers.
package soc_ahb3_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   typedef enum logic [1:0] {
      D_NONE,
      D_BUS,
      D_LOCAL_ERR
   } dstate_t;

endpackage

// File: rtl/soc_ahb3_sel_decode.sv
// Byte-enable decoder: maps an SRAM-style byte select
// onto legality, AHB hsize and the byte offset in the word.
module soc_ahb3_sel_decode
   import soc_ahb3_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN/8-1:0] sel,
   output logic              legal,
   output logic [2:0]        hsize,
   output logic [1:0]        offset
);

   logic [3:0] s;

   assign s = 4'(sel);

   // only naturally aligned byte, halfword and word patterns are legal
   always_comb begin
      legal  = 1'b0;
      hsize  = HSIZE_BYTE;
      offset = 2'd0;
      if (XLEN == 32) begin
         case (s)
            4'b0001: legal = 1'b1;
            4'b0010: begin legal = 1'b1; offset = 2'd1; end
            4'b0100: begin legal = 1'b1; offset = 2'd2; end
            4'b1000: begin legal = 1'b1; offset = 2'd3; end
            4'b0011: begin legal = 1'b1; hsize = HSIZE_HWORD; end
            4'b1100: begin
               legal  = 1'b1;
               hsize  = HSIZE_HWORD;
               offset = 2'd2;
            end
            4'b1111: begin legal = 1'b1; hsize = HSIZE_WORD; end
            default: legal = 1'b0;
         endcase
      end else if (XLEN == 16) begin
         case (s)
            4'b0001: legal = 1'b1;
            4'b0010: begin legal = 1'b1; offset = 2'd1; end
            4'b0011: begin legal = 1'b1; hsize = HSIZE_HWORD; end
            default: legal = 1'b0;
         endcase
      end else begin
         legal = (s == 4'b0001);
      end
   end

endmodule

// File: rtl/soc_sram2ahb3.sv
// AHB3-Lite single-transfer master fed by an SRAM-style
// req/gnt port; address phase of N+1 overlaps data phase of N.
module soc_sram2ahb3
   import soc_ahb3_pkg::*;
#(
   parameter int         PLEN  = 32,
   parameter int         XLEN  = 32,
   parameter logic [3:0] HPROT = HPROT_DATA_PRIV
) (
   input  logic              ahb3_clk_i,
   input  logic              ahb3_rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [PLEN-1:0]   addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [XLEN/8-1:0] sel_i,
   output logic              gnt_o,
   output logic              rsp_valid_o,
   output logic              rsp_err_o,
   output logic [XLEN-1:0]   rdata_o,
   output logic              ahb3_hsel_o,
   output logic [PLEN-1:0]   ahb3_haddr_o,
   output logic [XLEN-1:0]   ahb3_hwdata_o,
   output logic              ahb3_hwrite_o,
   output logic [2:0]        ahb3_hsize_o,
   output logic [2:0]        ahb3_hburst_o,
   output logic [3:0]        ahb3_hprot_o,
   output logic [1:0]        ahb3_htrans_o,
   output logic              ahb3_hmastlock_o,
   input  logic [XLEN-1:0]   ahb3_hrdata_i,
   input  logic              ahb3_hready_i,
   input  logic              ahb3_hresp_i
);

   localparam int SW      = XLEN / 8;
   localparam int BYTE_AW = SW >> 1;

   localparam logic [PLEN-1:0] OFF_MASK = PLEN'((1 << BYTE_AW) - 1);

   logic            legal;
   logic [2:0]      hsize;
   logic [1:0]      offset;
   dstate_t         dstate;
   logic [XLEN-1:0] hwdata_q;
   logic            we_q;
   logic            err1;
   logic            data_done;

   soc_ahb3_sel_decode #(
      .XLEN (XLEN)
   ) u_sel_decode (
      .sel    (sel_i),
      .legal  (legal),
      .hsize  (hsize),
      .offset (offset)
   );

   // first cycle of a two-cycle ERROR response blocks the next address phase
   assign err1 = (dstate == D_BUS) && ahb3_hresp_i && !ahb3_hready_i;

   assign data_done = (dstate != D_BUS) || ahb3_hready_i;

   assign gnt_o = req_i && ahb3_hready_i && !err1;

   assign ahb3_htrans_o = (req_i && legal && !err1) ? HTRANS_NONSEQ
                                                    : HTRANS_IDLE;

   assign ahb3_hsel_o      = (ahb3_htrans_o == HTRANS_NONSEQ);
   assign ahb3_haddr_o     = (addr_i & ~OFF_MASK) | PLEN'(offset);
   assign ahb3_hwrite_o    = we_i;
   assign ahb3_hsize_o     = hsize;
   assign ahb3_hburst_o    = HBURST_SINGLE;
   assign ahb3_hprot_o     = HPROT;
   assign ahb3_hmastlock_o = 1'b0;
   assign ahb3_hwdata_o    = hwdata_q;

   // response side follows whichever data phase is outstanding
   always_comb begin
      rsp_valid_o = 1'b0;
      rsp_err_o   = 1'b0;
      rdata_o     = '0;
      unique case (dstate)
         D_BUS: begin
            rsp_valid_o = ahb3_hready_i;
            rsp_err_o   = ahb3_hresp_i;
            if (!we_q) rdata_o = ahb3_hrdata_i;
         end
         D_LOCAL_ERR: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = 1'b1;
         end
         default: begin
            rsp_valid_o = 1'b0;
         end
      endcase
   end

   // data-phase tracker; a grant opens a new slot, completion closes it
   always_ff @(posedge ahb3_clk_i) begin
      if (ahb3_rst_i) begin
         dstate   <= D_NONE;
         hwdata_q <= '0;
         we_q     <= 1'b0;
      end else if (gnt_o) begin
         dstate   <= legal ? D_BUS : D_LOCAL_ERR;
         hwdata_q <= wdata_i;
         we_q     <= we_i;
      end else if (data_done) begin
         dstate   <= D_NONE;
      end
   end

endmodule

// File: tb/tb_soc_sram2ahb3.sv
// Randomised bench for soc_sram2ahb3: a transaction-level
// requester, AHB slave and reference memory run in lockstep.
module tb_soc_sram2ahb3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  sel;
   logic        gnt, rsp_valid, rsp_err;
   logic [31:0] rdata;
   logic        hsel, hwrite, hmastlock;
   logic [31:0] haddr, hwdata, hrdata;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hready, hresp;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   soc_sram2ahb3 dut (
      .ahb3_clk_i       (clk),
      .ahb3_rst_i       (rst),
      .req_i            (req),
      .we_i             (we),
      .addr_i           (addr),
      .wdata_i          (wdata),
      .sel_i            (sel),
      .gnt_o            (gnt),
      .rsp_valid_o      (rsp_valid),
      .rsp_err_o        (rsp_err),
      .rdata_o          (rdata),
      .ahb3_hsel_o      (hsel),
      .ahb3_haddr_o     (haddr),
      .ahb3_hwdata_o    (hwdata),
      .ahb3_hwrite_o    (hwrite),
      .ahb3_hsize_o     (hsize),
      .ahb3_hburst_o    (hburst),
      .ahb3_hprot_o     (hprot),
      .ahb3_htrans_o    (htrans),
      .ahb3_hmastlock_o (hmastlock),
      .ahb3_hrdata_i    (hrdata),
      .ahb3_hready_i    (hready),
      .ahb3_hresp_i     (hresp)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit sel_ok(input logic [3:0] s);
      return s inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] s);
      for (int i = 0; i < 4; i++)
         if (s[i]) return 2'(i);
      return 2'd0;
   endfunction

   function automatic logic [2:0] size_of(input logic [3:0] s);
      case ($countones(s))
         1: return 3'd0;
         2: return 3'd1;
         default: return 3'd2;
      endcase
   endfunction

   logic [31:0] ref_mem [16];
   logic [31:0] slv_mem [16];
   logic [3:0]  legal_sels [7] = '{4'h1, 4'h2, 4'h4, 4'h8,
                                   4'h3, 4'hC, 4'hF};

   // pending request on the SRAM side
   bit          r_act;
   logic        r_we;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_sel;

   // outstanding data phase: 0 none, 1 bus, 2 local error
   int          dp_kind;
   logic        dp_we;
   logic [31:0] dp_addr, dp_wdata;
   logic [3:0]  dp_sel;
   logic [2:0]  dp_size;
   int          dp_waits;
   bit          dp_err, dp_errstep;

   task automatic one_cycle();
      bit          err1, exp_gnt, done, ok;
      logic [31:0] exp_haddr;
      int          w;
      @(negedge clk);
      hresp  = 1'b0;
      hready = 1'b1;
      hrdata = $urandom;
      err1   = 1'b0;
      if (dp_kind == 1) begin
         if (dp_waits > 0) begin
            hready = 1'b0;
         end else if (dp_err && !dp_errstep) begin
            hready = 1'b0;
            hresp  = 1'b1;
            err1   = 1'b1;
         end else begin
            hresp = dp_err;
            if (!dp_we) hrdata = slv_mem[dp_addr[5:2]];
         end
      end
      if (!r_act && $urandom_range(0, 3) != 0) begin
         r_act   = 1'b1;
         r_we    = 1'($urandom);
         r_addr  = 32'h1000 | ($urandom_range(0, 15) << 2)
                 | $urandom_range(0, 3);
         r_wdata = $urandom;
         if ($urandom_range(0, 7) == 0) r_sel = 4'($urandom);
         else r_sel = legal_sels[$urandom_range(0, 6)];
      end
      req   = r_act;
      we    = r_act ? r_we : 1'($urandom);
      addr  = r_act ? r_addr : $urandom;
      wdata = r_act ? r_wdata : $urandom;
      sel   = r_act ? r_sel : 4'($urandom);
      #1;
      ok        = sel_ok(r_sel);
      exp_gnt   = r_act && hready && !err1;
      exp_haddr = {r_addr[31:2], low_idx(r_sel)};
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("htrans", 32'(htrans),
          (r_act && ok && !err1) ? 32'd2 : 32'd0);
      chk("hsel", 32'(hsel), 32'(r_act && ok && !err1));
      if (r_act && ok && !err1) begin
         chk("haddr", haddr, exp_haddr);
         chk("hsize", 32'(hsize), 32'(size_of(r_sel)));
         chk("hwrite", 32'(hwrite), 32'(r_we));
      end
      chk("rsp_valid", 32'(rsp_valid),
          (dp_kind == 1) ? 32'(hready) : 32'(dp_kind == 2));
      chk("rsp_err", 32'(rsp_err),
          (dp_kind == 1) ? 32'(hresp) : 32'(dp_kind == 2));
      if (dp_kind == 1 && hready && !dp_err) begin
         w = int'(dp_addr[5:2]);
         if (!dp_we) begin
            chk("rdata", rdata, ref_mem[w]);
         end else begin
            chk("hwdata", hwdata, dp_wdata);
            for (int b = 0; b < 4; b++) begin
               if (b >= int'(dp_addr[1:0]) &&
                   b < int'(dp_addr[1:0]) + (1 << dp_size))
                  slv_mem[w][8*b +: 8] = hwdata[8*b +: 8];
               if (dp_sel[b])
                  ref_mem[w][8*b +: 8] = dp_wdata[8*b +: 8];
            end
         end
      end
      done = (dp_kind != 1) || hready;
      if (dp_kind == 1 && !done) begin
         if (dp_waits > 0) dp_waits--;
         else dp_errstep = 1'b1;
      end
      if (exp_gnt) begin
         dp_kind    = ok ? 1 : 2;
         dp_we      = r_we;
         dp_addr    = exp_haddr;
         dp_wdata   = r_wdata;
         dp_sel     = r_sel;
         dp_size    = size_of(r_sel);
         dp_waits   = ($urandom_range(0, 1) == 0) ? 0
                                                  : $urandom_range(1, 2);
         dp_err     = ($urandom_range(0, 7) == 0);
         dp_errstep = 1'b0;
         r_act      = 1'b0;
      end else if (done) begin
         dp_kind = 0;
      end
   endtask

   task automatic reset_and_check(input string tag);
      @(negedge clk);
      rst    = 1'b1;
      req    = 1'b0;
      hready = 1'b1;
      hresp  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tag, "_htrans"}, 32'(htrans), 32'd0);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, "_hwdata"}, hwdata, 32'd0);
      chk({tag, "_hburst"}, 32'(hburst), 32'd0);
      chk({tag, "_hprot"}, 32'(hprot), 32'd3);
      chk({tag, "_hmastlock"}, 32'(hmastlock), 32'd0);
      r_act   = 1'b0;
      r_sel   = 4'h0;
      dp_kind = 0;
   endtask

   initial begin
      rst    = 1'b1;
      req    = 1'b0;
      we     = 1'b0;
      addr   = '0;
      wdata  = '0;
      sel    = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         slv_mem[i] = ref_mem[i];
      end
      reset_and_check("reset");
      repeat (3000) one_cycle();
      reset_and_check("mid_reset");
      repeat (500) one_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
